// File: rtl/fsm_rd_prog.sv
// Programmable table-driven Moore FSM: next-state and output tables are written while halted.
// Optional build macro FSM_RD_PARITY_EN adds per-entry even parity with a sticky fault.
module fsm_rd_prog #(
    parameter int IN_W     = 2,
    parameter int ST_W     = 2,
    parameter int OUT_W    = 8,
    parameter int RESET_ST = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_W-1:0]      ptext,
    input  logic                 run,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [ST_W+IN_W-1:0] cfg_addr,
    input  logic [OUT_W-1:0]     cfg_wdata,
    output logic [OUT_W-1:0]     rtext,
    output logic [ST_W-1:0]      st,
    output logic                 trans,
    output logic                 cfg_rej,
    output logic                 err
);

    localparam int AW = ST_W + IN_W;
    localparam int NS = 1 << ST_W;
    localparam int NA = 1 << AW;
    localparam logic [ST_W-1:0] RST_ST = ST_W'(RESET_ST);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  nxt_tbl [NA];
    logic [OUT_W-1:0] out_tbl [NS];

    logic [AW-1:0]    rd_idx;
    logic [ST_W-1:0]  nxt_st;
    logic [ST_W-1:0]  out_idx;
    logic             go;
    logic             fault;

    assign rd_idx  = {state, ptext};
    assign nxt_st  = nxt_tbl[rd_idx];
    assign out_idx = cfg_addr[ST_W-1:0];
    assign rtext   = out_tbl[state];
    assign st      = state;

`ifdef FSM_RD_PARITY_EN
    logic nxt_par [NA];
    logic out_par [NS];
    logic err_q;

    function automatic logic even_par(input logic [OUT_W-1:0] d);
        return ^d;
    endfunction

    assign fault = (even_par(OUT_W'(nxt_st)) ^ nxt_par[rd_idx])
                 | (even_par(out_tbl[state]) ^ out_par[state]);
    // A latched fault freezes the machine exactly as if run were low.
    assign go    = run & ~err_q;
    assign err   = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
            for (int i = 0; i < NA; i++) nxt_par[i] <= 1'b0;
            for (int i = 0; i < NS; i++) out_par[i] <= 1'b0;
        end else begin
            if (cfg_we && !go) begin
                if (cfg_sel) out_par[out_idx] <= even_par(cfg_wdata);
                else         nxt_par[cfg_addr] <= even_par(OUT_W'(cfg_wdata[ST_W-1:0]));
            end
            if (go && fault) err_q <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
    assign go    = run;
    assign err   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RST_ST;
            trans   <= 1'b0;
            cfg_rej <= 1'b0;
            for (int i = 0; i < NA; i++) nxt_tbl[i] <= '0;
            for (int i = 0; i < NS; i++) out_tbl[i] <= '0;
        end else begin
            cfg_rej <= cfg_we & go;
            trans   <= 1'b0;
            // Writes and advances are mutually exclusive, so the lookup never sees a same-edge write.
            if (cfg_we && !go) begin
                if (cfg_sel) out_tbl[out_idx]  <= cfg_wdata;
                else         nxt_tbl[cfg_addr] <= cfg_wdata[ST_W-1:0];
            end
            if (go) begin
                if (fault) begin
                    state <= RST_ST;
                    trans <= (state != RST_ST);
                end else begin
                    state <= nxt_st;
                    trans <= (nxt_st != state);
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_rd_prog.sv
// Randomized self-checking bench for fsm_rd_prog against a table-level reference model.
module tb_fsm_rd_prog;

    logic       CLK;
    logic       RST;
    logic [1:0] ptext;
    logic       run;
    logic       cfg_we;
    logic       cfg_sel;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] rtext;
    logic [1:0] st;
    logic       trans;
    logic       cfg_rej;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: plain tables indexed by state*4 + symbol
    int m_nxt [16];
    int m_out [4];
    int m_st;

    fsm_rd_prog dut (
        .CLK(CLK), .RST(RST), .ptext(ptext), .run(run),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .rtext(rtext), .st(st), .trans(trans), .cfg_rej(cfg_rej), .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_nxt[i] = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 0;
        m_st = 0;
    endtask

    task automatic step(input logic r, input logic [1:0] p, input logic we, input logic sel,
                        input logic [3:0] a, input logic [7:0] d);
        int exp_rej;
        int exp_trans;
        int ns;
        run = r; ptext = p; cfg_we = we; cfg_sel = sel; cfg_addr = a; cfg_wdata = d;
        @(posedge CLK);
        exp_rej   = (we && r) ? 1 : 0;
        exp_trans = 0;
        if (we && !r) begin
            if (sel) m_out[a % 4] = d;
            else     m_nxt[a] = d % 4;
        end
        if (r) begin
            ns = m_nxt[m_st * 4 + p];
            exp_trans = (ns != m_st) ? 1 : 0;
            m_st = ns;
        end
        #1;
        cfg_we = 1'b0;
        chk("st", st, m_st);
        chk("rtext", rtext, m_out[m_st]);
        chk("trans", trans, exp_trans);
        chk("cfg_rej", cfg_rej, exp_rej);
        chk("err", err, 0);
    endtask

    initial begin
        RST = 1'b1; run = 1'b1; ptext = 2'($urandom);
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();

        // reset held with run=1 and changing symbols
        #1;
        for (int i = 0; i < 4; i++) begin
            ptext = 2'($urandom);
            chk("rst_st", st, 0);
            chk("rst_rtext", rtext, 0);
            chk("rst_trans", trans, 0);
            chk("rst_rej", cfg_rej, 0);
            chk("rst_err", err, 0);
            @(posedge CLK); #1;
        end
        RST = 1'b0;

        // program the 4-state machine
        step(0, 2'($urandom), 1, 1, 4'd0, 8'h38);
        step(0, 2'($urandom), 1, 1, 4'd1, 8'h64);
        step(0, 2'($urandom), 1, 1, 4'd2, 8'hE4);
        step(0, 2'($urandom), 1, 1, 4'd3, 8'h98);
        step(0, 2'($urandom), 1, 0, 4'd1, 8'h02);
        step(0, 2'($urandom), 1, 0, 4'd9, 8'h02);
        chk("halt_st0", st, 0);
        chk("halt_rtext38", rtext, 8'h38);

        step(1, 2'b01, 0, 0, 4'd0, 8'h00);
        chk("adv_st", st, 2);
        chk("adv_rtext", rtext, 8'hE4);
        chk("adv_trans", trans, 1);
        step(1, 2'b01, 0, 0, 4'd0, 8'h00);
        chk("selfloop_trans", trans, 0);
        chk("selfloop_st", st, 2);

        for (int i = 0; i < 5; i++) begin
            step(0, 2'($urandom), 0, 0, 4'd0, 8'h00);
            chk("hold_st", st, 2);
            chk("hold_rtext", rtext, 8'hE4);
            chk("hold_trans", trans, 0);
        end

        // write while running: rejected, state 2 --00--> 0 via reset-zero entry
        step(1, 2'b00, 1, 1, 4'd0, 8'hFF);
        chk("rej_pulse", cfg_rej, 1);
        chk("rej_st", st, 0);
        chk("rej_rtext", rtext, 8'h38);
        step(0, 2'b00, 0, 0, 4'd0, 8'h00);
        chk("rej_once", cfg_rej, 0);

        // go to state 1, halt and rewrite its output
        step(0, 2'b00, 1, 0, 4'd0, 8'h01);
        step(1, 2'b00, 0, 0, 4'd0, 8'h00);
        chk("s1_st", st, 1);
        chk("s1_rtext", rtext, 8'h64);
        step(0, 2'b00, 1, 1, 4'd1, 8'hA5);
        chk("s1_new_rtext", rtext, 8'hA5);

        // asynchronous reset mid-cycle while running
        run = 1'b1; ptext = 2'b00;
        #2 RST = 1'b1;
        #1;
        chk("arst_st", st, 0);
        chk("arst_rtext", rtext, 0);
        chk("arst_trans", trans, 0);
        chk("arst_rej", cfg_rej, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        chk("arst_tbl_lost", rtext, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 1) == 1), 2'($urandom), ($urandom_range(0, 2) == 0),
                 1'($urandom), 4'($urandom), 8'($urandom));
        end

`ifdef FSM_RD_PARITY_EN
        RST = 1'b1; #1; @(posedge CLK); #1; RST = 1'b0;
        force dut.nxt_tbl[1] = 2'b01;
        run = 1'b1; ptext = 2'b01;
        @(posedge CLK); #1;
        release dut.nxt_tbl[1];
        chk("par_st", st, 0);
        chk("par_err", err, 1);
        for (int i = 0; i < 3; i++) begin
            ptext = 2'($urandom);
            @(posedge CLK); #1;
            chk("par_hold_st", st, 0);
            chk("par_sticky", err, 1);
        end
        RST = 1'b1; #1;
        chk("par_clear", err, 0);
        @(posedge CLK); #1; RST = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsm_rd_prog.md
# fsm_rd_prog

Table-driven Moore state machine for the fsm_rd family, generalised from the fixed 4-state, 2-bit-input, 8-bit-output form to parametrised state, input and output widths. The transition and output tables are writable registers loaded over a configuration port while the machine is halted, so one netlist can realise any machine of the configured size. It sits where a fixed fsm_rd_* instance would: ptext in, rtext out, with added run control and status.

## Interface
- IN_W, 2: input symbol width (ptext); 1..4.
- ST_W, 2: state width; 2^ST_W states; 1..4.
- OUT_W, 8: output word width; must be >= ST_W.
- RESET_ST, 0: state entered on reset and on parity fault.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- ptext  in  IN_W  input symbol, sampled on each CLK edge while run=1.
- run  in  1  1 = advance state each cycle; 0 = hold (halted).
- cfg_we  in  1  table write strobe, single cycle.
- cfg_sel  in  1  0 = next-state table, 1 = output table.
- cfg_addr  in  ST_W+IN_W  next-state: {state, symbol}; output: low ST_W bits = state, upper bits ignored.
- cfg_wdata  in  OUT_W  write data; next-state table uses low ST_W bits.
- rtext  out  OUT_W  out_tbl[State] (Moore output).
- st  out  ST_W  current state.
- trans  out  1  one-cycle pulse: State changed on the last edge.
- cfg_rej  out  1  one-cycle pulse: write rejected (run=1).
- err  out  1  sticky parity fault (FSM_RD_PARITY_EN only; else tied 0).

## Operation
- Storage: nxt_tbl, 2^(ST_W+IN_W) entries x ST_W; out_tbl, 2^ST_W entries x OUT_W; all flops.
- Reset (async): State=RESET_ST; every table entry 0; trans=0, cfg_rej=0, err=0; hence rtext=0, st=RESET_ST.
- run=1: State <= nxt_tbl[{State, ptext}] each edge. trans=1 next cycle iff new State != old State (self-loops give trans=0).
- run=0: State holds; trans=0.
- Config write (cfg_we=1, run=0): addressed entry updated at the edge. Output-table write to current state changes rtext from the next cycle.
- Config write with run=1: ignored, tables unchanged, cfg_rej=1 next cycle; state advance proceeds normally.
- cfg_we with run rising in the same cycle: run is sampled, so write rejected.
- rtext is combinational from State and out_tbl; no glitch constraint beyond flop outputs.
- Unused state codes do not exist: every ST_W code is a legal state.

## Timing
- State latency: ptext at edge n -> st and rtext updated after edge n (one cycle).
- Write latency: entry visible to the next-state lookup at edge n+1 after write at edge n.
- trans and cfg_rej are registered, valid for exactly one cycle after the causing edge.
- RST mid-run: immediate return to reset values regardless of CLK; table contents lost.

## Configuration
- FSM_RD_PARITY_EN defined: each table entry carries one even-parity bit computed on write (reset entries: data 0, parity 0). Each advancing edge checks the nxt_tbl entry read and out_tbl[State]; on mismatch: State <= RESET_ST, err <= 1 (sticky until RST), further advance inhibited (treated as run=0) until RST. Config writes remain accepted while err=1.
- Undefined: no parity storage or checker; err tied 0; fault path absent.

## Test plan
- Reset: assert RST with run=1, random ptext -> st=0, rtext=0x00, trans=0, cfg_rej=0, err=0 throughout RST.
- Program 4-state machine (out_tbl = 0x38, 0x64, 0xE4, 0x98; nxt_tbl[{0,2'b01}]=2), run=1, ptext=01 -> after one edge st=2, rtext=0xE4, trans=1; hold ptext with self-loop nxt_tbl[{2,01}]=2 -> trans=0.
- run=0 for 5 cycles with changing ptext -> st, rtext unchanged, trans=0.
- Write with run=1 (cfg_sel=1, addr=0, data=0xFF) -> cfg_rej=1 one cycle, out_tbl[0] unchanged (rtext=0x38 when in state 0).
- Halted in state 1, write out_tbl[1]=0xA5 -> rtext=0xA5 next cycle; RST pulse mid-run -> st=0, all outputs 0 immediately.
- FSM_RD_PARITY_EN: force-flip a stored nxt_tbl bit via bench, run=1 -> State=0, err=1, no further advance; only RST clears err.
